qam_frame_sequencer: RTL

- Single-clock controller that sequences the demapper symbol FIFO in fixed-length frames.
- Write side: gates demapped symbols into the FIFO until a frame of FRAME_LEN symbols is captured.
- Read side: raises available to the host and serves host burst requests of BURST_LEN symbols until the frame is drained.
- Adds drop counting, underflow detection and a FIFO flush pulse. Sits between the hard-decision demapper output and the host interface, in the dclk domain.

---
 rtl/qam_frame_sequencer_if.sv | 36 +++
 rtl/qam_frame_sequencer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/qam_frame_sequencer_if.sv
// Demapper, symbol FIFO and host signals around the frame sequencer.
// master drives the sequencer inputs (environment side); slave is the sequencer.
interface qam_frame_sequencer_if #(
  parameter int unsigned SYM_W  = 4,
  parameter int unsigned DROP_W = 8
);
  logic              enable;
  logic              sym_valid;
  logic [SYM_W-1:0]  sym_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic [SYM_W-1:0]  fifo_q;
  logic              host_req;
  logic              fifo_wrreq;
  logic [SYM_W-1:0]  fifo_data;
  logic              fifo_rdreq;
  logic              fifo_aclr;
  logic              host_valid;
  logic [SYM_W-1:0]  host_data;
  logic              available;
  logic              complete;
  logic [DROP_W-1:0] drop_count;
  logic              underflow;

  modport master (
    output enable, sym_valid, sym_data, fifo_full, fifo_empty, fifo_q, host_req,
    input  fifo_wrreq, fifo_data, fifo_rdreq, fifo_aclr, host_valid, host_data,
           available, complete, drop_count, underflow
  );

  modport slave (
    input  enable, sym_valid, sym_data, fifo_full, fifo_empty, fifo_q, host_req,
    output fifo_wrreq, fifo_data, fifo_rdreq, fifo_aclr, host_valid, host_data,
           available, complete, drop_count, underflow
  );
endinterface

// File: rtl/qam_frame_sequencer.sv
// Frame sequencer for the demapper symbol FIFO: captures FRAME_LEN symbols,
// then serves host bursts of up to BURST_LEN symbols until the frame is drained.
module qam_frame_sequencer #(
  parameter int unsigned SYM_W     = 4,
  parameter int unsigned FRAME_LEN = 64,
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned CNT_W     = 7,
  parameter int unsigned DROP_W    = 8
) (
  input  logic                 dclk,
  input  logic                 reset,
  qam_frame_sequencer_if.slave bus
);

  localparam int unsigned       BCNT_W     = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]  FRAME_END  = CNT_W'(FRAME_LEN);
  localparam logic [BCNT_W-1:0] BURST_LAST = BCNT_W'(BURST_LEN - 1);
  localparam logic [BCNT_W-1:0] BURST_END  = BCNT_W'(BURST_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_READY,
    S_BURST,
    S_BTAIL,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [BCNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic                underflow_q, underflow_d;
  logic                host_valid_q, host_valid_d;
  logic                aclr_q, aclr_d;

  logic                wrreq_c, rdreq_c, drop_c, available_c, complete_c, reads_left_c;

  // Next-state, counters and request strobes
  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    burst_cnt_d  = burst_cnt_q;
    drop_d       = drop_q;
    underflow_d  = underflow_q;
    wrreq_c      = 1'b0;
    rdreq_c      = 1'b0;
    drop_c       = 1'b0;
    available_c  = 1'b0;
    complete_c   = 1'b0;
    reads_left_c = (burst_cnt_q < BURST_END) && (rd_cnt_q < FRAME_END);

    case (state_q)
      S_IDLE: begin
        complete_c = 1'b1;
        if (bus.enable) begin
          state_d  = S_FILL;
          wr_cnt_d = '0;
          rd_cnt_d = '0;
        end
      end
      S_FILL: begin
        wrreq_c = bus.sym_valid & ~bus.fifo_full;
        drop_c  = bus.sym_valid & bus.fifo_full;
        if (wrreq_c) begin
          wr_cnt_d = wr_cnt_q + CNT_W'(1);
          if (wr_cnt_q == FRAME_LAST) state_d = S_READY;
        end
      end
      S_READY: begin
        available_c = 1'b1;
        drop_c      = bus.sym_valid;
        if (bus.host_req) begin
          state_d     = S_BURST;
          burst_cnt_d = '0;
        end
      end
      S_BURST: begin
        available_c = 1'b1;
        drop_c      = bus.sym_valid;
        if (reads_left_c && !bus.fifo_empty) begin
          rdreq_c     = 1'b1;
          burst_cnt_d = burst_cnt_q + BCNT_W'(1);
          rd_cnt_d    = rd_cnt_q + CNT_W'(1);
          // Leave on the last read so no idle BURST cycle precedes the tail
          if ((burst_cnt_q == BURST_LAST) || (rd_cnt_q == FRAME_LAST)) state_d = S_BTAIL;
        end else begin
          if (reads_left_c) underflow_d = 1'b1;
          state_d = S_BTAIL;
        end
      end
      S_BTAIL: begin
        available_c = 1'b1;
        drop_c      = bus.sym_valid;
        state_d     = (rd_cnt_q == FRAME_END) ? S_DONE : S_READY;
      end
      S_DONE: begin
        complete_c = 1'b1;
        wr_cnt_d   = '0;
        rd_cnt_d   = '0;
        state_d    = bus.enable ? S_FILL : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Dropping enable aborts everything else in the same cycle
    if ((state_q != S_IDLE) && !bus.enable) begin
      state_d     = S_IDLE;
      wrreq_c     = 1'b0;
      rdreq_c     = 1'b0;
      drop_c      = 1'b0;
      underflow_d = underflow_q;
    end

    if (drop_c && (drop_q != '1)) drop_d = drop_q + DROP_W'(1);

    host_valid_d = rdreq_c;
    aclr_d       = (state_q != S_IDLE) && (state_d == S_IDLE);
  end

  always_ff @(posedge dclk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      burst_cnt_q  <= '0;
      drop_q       <= '0;
      underflow_q  <= 1'b0;
      host_valid_q <= 1'b0;
      aclr_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      drop_q       <= drop_d;
      underflow_q  <= underflow_d;
      host_valid_q <= host_valid_d;
      aclr_q       <= aclr_d;
    end
  end

  // FIFO q arrives one cycle after rdreq, aligned with host_valid
  assign bus.fifo_wrreq = wrreq_c & ~reset;
  assign bus.fifo_data  = bus.sym_data;
  assign bus.fifo_rdreq = rdreq_c & ~reset;
  assign bus.fifo_aclr  = aclr_q;
  assign bus.host_valid = host_valid_q;
  assign bus.host_data  = host_valid_q ? bus.fifo_q : SYM_W'(0);
  assign bus.available  = available_c;
  assign bus.complete   = complete_c;
  assign bus.drop_count = drop_q;
  assign bus.underflow  = underflow_q;

endmodule
